jk_updown_counter: RTL
======================

JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the counter bit width.
REQ-002 The block SHALL have parameter MODULUS, default 10, meaning the count range 0..MODULUS-1, legal range 2..2^WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous parallel load.
REQ-008 The block SHALL have port load_val, input, WIDTH bits: the value to load.
REQ-009 The block SHALL have port count, output, WIDTH bits: the registered count, taken from the JK stage q outputs.
REQ-010 The block SHALL have port tc, output, 1 bit: terminal count, combinational.
REQ-011 The block SHALL have ports j_out and k_out, output, WIDTH bits each: the per-bit J/K excitation currently applied to the stages.

Function
REQ-012 Each count bit SHALL be held in a JK stage; the next state SHALL be reached only through J/K excitation, with no direct D path.
REQ-013 Excitation SHALL be computed per bit as follows:
- J = ~q & nxt.
- K = q & ~nxt.
- nxt is the target next count.
- With both J and K at 0, the bit SHALL hold.
REQ-014 Priority SHALL be: reset, then load, then en, then hold.
REQ-015 When load=1 at an edge, count SHALL become load_val, or MODULUS-1 if load_val >= MODULUS, regardless of en and up.
REQ-016 With load=0 and en=1, up=1, count SHALL increment by 1 per edge, and SHALL go from MODULUS-1 to 0.
REQ-017 With load=0 and en=1, up=0, count SHALL decrement by 1 per edge, and SHALL go from 0 to MODULUS-1.
REQ-018 With load=0 and en=0, count SHALL hold, and j_out and k_out SHALL be all zero.
REQ-019 tc SHALL equal en & ~load & ((up & count==MODULUS-1) | (~up & count==0)).
REQ-020 Latency from a load or enable edge to the updated count SHALL be exactly one clk cycle.
REQ-021 A change of up on the same edge as a count SHALL take effect on that edge; there is no direction pipeline.

Reset
REQ-022 On rst_n=0, count SHALL be driven to 0 immediately and asynchronously, without waiting for clk.
REQ-023 While rst_n=0, tc, j_out and k_out SHALL be 0.
REQ-024 Reset asserted mid-count SHALL discard any pending load or increment.
REQ-025 Reset release SHALL be honoured on the first rising clk edge after rst_n returns to 1.

Configuration
REQ-026 With macro JK_UPDOWN_COUNTER_SAT_EN defined, the count SHALL saturate:
- Counting up at MODULUS-1 SHALL hold at MODULUS-1.
- Counting down at 0 SHALL hold at 0.
- tc SHALL still assert per REQ-019.
REQ-027 Without JK_UPDOWN_COUNTER_SAT_EN, the count SHALL wrap per REQ-016 and REQ-017.

Structure
REQ-028 Package jk_counter_pkg SHALL hold:
- The default WIDTH and MODULUS constants.
- A direction constant pair, UP=1 and DOWN=0.
REQ-029 One sub-module, jk_cell, SHALL implement a single JK stage:
- Inputs clk, rst_n, j, k; output q.
- Asynchronous active-low clear.
- Standard JK behaviour: hold, reset, set, toggle.
REQ-030 The top SHALL instantiate WIDTH jk_cell instances and contain only the next-state, excitation and tc logic.

Verification (WIDTH=4, MODULUS=10)
REQ-031 Reset and enable: assert rst_n=0 mid-cycle -> count=0 before the next clk edge. Release, en=1, up=1 for 12 edges -> 1..9, 0, 1, 2; tc=1 only while count=9.
REQ-032 Down wrap: count=0, en=1, up=0 -> next count=9; tc=1 during count=0; j_out=1001 and k_out=0000 in that cycle.
REQ-033 Load: load=1, load_val=7, en=1 -> count=7. Then load_val=12 -> count=9 (clamped). tc=0 whenever load=1.
REQ-034 Hold: en=0 for 5 edges at count=4 -> count stays 4, and j_out=k_out=0000 throughout.
REQ-035 Saturate, with JK_UPDOWN_COUNTER_SAT_EN: count=9, up=1, 3 edges -> stays 9. Then up=0 from 0 -> stays 0.
REQ-036 Direction flip: at count=5, toggle up every edge -> 6, 5, 6, 5. Check excitation on the 5->6 step: j_out=0010, k_out=0001.

Source files
------------

// File: rtl/jk_counter_pkg.sv
// rtl/jk_counter_pkg.sv - shared constants for the JK up/down counter
package jk_counter_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MODULUS = 10;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

endpackage : jk_counter_pkg

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop stage with asynchronous active-low clear
module jk_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic r_q;

    // JK state update: 00 hold, 01 reset, 10 set, 11 toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule : jk_cell

// File: rtl/jk_updown_counter.sv
// rtl/jk_updown_counter.sv - mod-MODULUS up/down counter on JK stages (JK_UPDOWN_COUNTER_SAT_EN: saturate instead of wrap)
module jk_updown_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_at_max  = (w_q == MAX_CNT);
    assign w_at_zero = (w_q == '0);

    // Target next count: load (clamped) beats enable, otherwise hold
    always_comb begin
        w_nxt = w_q;
        if (load) begin
            w_nxt = (load_val > MAX_CNT) ? MAX_CNT : load_val;
        end else if (en) begin
            if (up == UP) begin
`ifdef JK_UPDOWN_COUNTER_SAT_EN
                w_nxt = w_at_max ? MAX_CNT : w_q + WIDTH'(1);
`else
                w_nxt = w_at_max ? '0 : w_q + WIDTH'(1);
`endif
            end else begin
`ifdef JK_UPDOWN_COUNTER_SAT_EN
                w_nxt = w_at_zero ? '0 : w_q - WIDTH'(1);
`else
                w_nxt = w_at_zero ? MAX_CNT : w_q - WIDTH'(1);
`endif
            end
        end
    end

    // Excitation drives only the bits that must change; forced quiet in reset
    assign w_j = {WIDTH{rst_n}} & ~w_q &  w_nxt;
    assign w_k = {WIDTH{rst_n}} &  w_q & ~w_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .j     (w_j[gi]),
                .k     (w_k[gi]),
                .q     (w_q[gi])
            );
        end
    endgenerate

    assign count = w_q;
    assign j_out = w_j;
    assign k_out = w_k;
    assign tc    = rst_n & en & ~load & ((up & w_at_max) | (~up & w_at_zero));

endmodule : jk_updown_counter
